level_port_arbiter: RTL and testbench

LEVEL_PORT_ARBITER -- requirements
Module: level_port_arbiter

---
 rtl/level_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_level_port_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/level_port_arbiter.sv
// Purpose: arbitrates requesters A (sift/pop) and B (insert) onto one shared heap-level
//          memory port, with round-robin priority and bounded read-modify-write locking.
// Ports:   clk/rst; per-side req/lock/addr/wr_en/data in, gnt/q/valid out; shared port
//          addr_U/wr_en_U/data_U out, q_U in (one-cycle read latency).
module level_port_arbiter #(
  parameter int LEVEL    = 3,
  parameter int WIDTH    = 15,
  parameter int LOCK_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_A,
  input  logic             req_B,
  input  logic             lock_A,
  input  logic             lock_B,
  input  logic [LEVEL-2:0] addr_A,
  input  logic [LEVEL-2:0] addr_B,
  input  logic             wr_en_A,
  input  logic             wr_en_B,
  input  logic [WIDTH:0]   data_A,
  input  logic [WIDTH:0]   data_B,
  output logic             gnt_A,
  output logic             gnt_B,
  output logic [WIDTH:0]   q_A,
  output logic [WIDTH:0]   q_B,
  output logic             valid_A,
  output logic             valid_B,
  output logic [LEVEL-2:0] addr_U,
  output logic             wr_en_U,
  output logic [WIDTH:0]   data_U,
  input  logic [WIDTH:0]   q_U
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK_A   = 2'd1,
    LOCK_B   = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  state_t         state_q, state_d;
  logic [3:0]     lock_cnt_q, lock_cnt_d;
  logic           prio_q, prio_d;
  // One-cycle exclusion of a side whose lock just ran out.
  logic           excl_a_q, excl_a_d;
  logic           excl_b_q, excl_b_d;
  logic           valid_a_q, valid_a_d;
  logic           valid_b_q, valid_b_d;
  logic [WIDTH:0] q_a_hold_q, q_a_hold_d;
  logic [WIDTH:0] q_b_hold_q, q_b_hold_d;

  logic           gnt_a, gnt_b;
  logic           elig_a, elig_b;
  logic           owner_active;
  logic [3:0]     cnt_inc;

  // Grant selection and next-state logic.
  always_comb begin
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    elig_a       = req_A & ~excl_a_q;
    elig_b       = req_B & ~excl_b_q;
    owner_active = ((state_q == LOCK_A) && req_A) || ((state_q == LOCK_B) && req_B);
    cnt_inc      = 4'(lock_cnt_q + 4'd1);

    state_d    = UNLOCKED;
    lock_cnt_d = 4'd0;
    excl_a_d   = 1'b0;
    excl_b_d   = 1'b0;

    if (rst) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else if (owner_active) begin
      // Lock owner is still requesting: it wins regardless of prio or the other side.
      gnt_a = (state_q == LOCK_A);
      gnt_b = (state_q == LOCK_B);
      if ((gnt_a && lock_A) || (gnt_b && lock_B)) begin
        lock_cnt_d = cnt_inc;
        if (cnt_inc == LOCK_MAX_C) begin
          // Lock budget spent: drop to UNLOCKED and bar the owner for one cycle.
          state_d  = UNLOCKED;
          excl_a_d = gnt_a;
          excl_b_d = gnt_b;
        end else begin
          state_d = state_q;
        end
      end
    end else begin
      // Unlocked arbitration (also taken when a lock owner withdrew its request).
      if (elig_a && elig_b) begin
        gnt_a = ~prio_q;
        gnt_b = prio_q;
      end else begin
        gnt_a = elig_a;
        gnt_b = elig_b;
      end
      if (gnt_a && lock_A) begin
        state_d = LOCK_A;
      end else if (gnt_b && lock_B) begin
        state_d = LOCK_B;
      end
    end

    // Contended grant hands priority to the loser; uncontended leaves it alone.
    prio_d = prio_q;
    if (req_A && req_B && (gnt_a || gnt_b)) begin
      prio_d = gnt_a;
    end

    valid_a_d  = gnt_a & ~wr_en_A;
    valid_b_d  = gnt_b & ~wr_en_B;
    q_a_hold_d = valid_a_q ? q_U : q_a_hold_q;
    q_b_hold_d = valid_b_q ? q_U : q_b_hold_q;
  end

  // Shared-port mux; zeros when idle.
  always_comb begin
    addr_U  = '0;
    wr_en_U = 1'b0;
    data_U  = '0;
    if (gnt_a) begin
      addr_U  = addr_A;
      wr_en_U = wr_en_A;
      data_U  = data_A;
    end else if (gnt_b) begin
      addr_U  = addr_B;
      wr_en_U = wr_en_B;
      data_U  = data_B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      lock_cnt_q <= 4'd0;
      prio_q     <= 1'b0;
      excl_a_q   <= 1'b0;
      excl_b_q   <= 1'b0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      q_a_hold_q <= '0;
      q_b_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      prio_q     <= prio_d;
      excl_a_q   <= excl_a_d;
      excl_b_q   <= excl_b_d;
      valid_a_q  <= valid_a_d;
      valid_b_q  <= valid_b_d;
      q_a_hold_q <= q_a_hold_d;
      q_b_hold_q <= q_b_hold_d;
    end
  end

  assign gnt_A   = gnt_a;
  assign gnt_B   = gnt_b;
  assign valid_A = valid_a_q;
  assign valid_B = valid_b_q;
  // Read data passes straight from the port in its valid cycle, then is held.
  assign q_A     = valid_a_q ? q_U : q_a_hold_q;
  assign q_B     = valid_b_q ? q_U : q_b_hold_q;

endmodule

// File: tb/tb_level_port_arbiter.sv
module tb_level_port_arbiter;

  localparam int LEVEL = 3;
  localparam int WIDTH = 15;

  typedef struct {
    logic           side;   // 0 = A, 1 = B
    logic [WIDTH:0] data;
  } rd_exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_A, req_B, lock_A, lock_B, wr_en_A, wr_en_B;
  logic [LEVEL-2:0] addr_A, addr_B;
  logic [WIDTH:0]   data_A, data_B;
  logic             gnt_A, gnt_B, valid_A, valid_B, wr_en_U;
  logic [WIDTH:0]   q_A, q_B, data_U, q_U;
  logic [LEVEL-2:0] addr_U;

  logic [WIDTH:0]   mem    [4];
  logic [WIDTH:0]   shadow [4];
  rd_exp_t          sb [$];
  logic [WIDTH:0]   last_qa, last_qb;
  int               checks = 0;
  int               errors = 0;

  level_port_arbiter #(.LEVEL(LEVEL), .WIDTH(WIDTH), .LOCK_MAX(15)) dut (
    .clk(clk), .rst(rst),
    .req_A(req_A), .req_B(req_B), .lock_A(lock_A), .lock_B(lock_B),
    .addr_A(addr_A), .addr_B(addr_B), .wr_en_A(wr_en_A), .wr_en_B(wr_en_B),
    .data_A(data_A), .data_B(data_B),
    .gnt_A(gnt_A), .gnt_B(gnt_B), .q_A(q_A), .q_B(q_B),
    .valid_A(valid_A), .valid_B(valid_B),
    .addr_U(addr_U), .wr_en_U(wr_en_U), .data_U(data_U), .q_U(q_U)
  );

  always #5 clk = ~clk;

  // Shared level memory: one-cycle read latency.
  always @(posedge clk) begin
    if (wr_en_U) mem[addr_U] <= data_U;
    q_U <= mem[addr_U];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs already driven; check grants, shared port, valid/q, then advance.
  task automatic tick(input logic ega, input logic egb);
    rd_exp_t        e;
    logic           had;
    logic           rst_s;
    logic [LEVEL-2:0] ea;
    logic           ew;
    logic [WIDTH:0] ed;
    #3;
    check("gnt_A", 32'(gnt_A), 32'(ega));
    check("gnt_B", 32'(gnt_B), 32'(egb));
    ea = ega ? addr_A : (egb ? addr_B : '0);
    ew = ega ? wr_en_A : (egb ? wr_en_B : 1'b0);
    ed = ega ? data_A : (egb ? data_B : '0);
    check("addr_U", 32'(addr_U), 32'(ea));
    check("wr_en_U", 32'(wr_en_U), 32'(ew));
    check("data_U", 32'(data_U), 32'(ed));
    had = (sb.size() > 0);
    if (had) e = sb.pop_front();
    check("valid_A", 32'(valid_A), 32'(had && !e.side));
    check("valid_B", 32'(valid_B), 32'(had && e.side));
    if (had && !e.side) last_qa = e.data;
    if (had && e.side)  last_qb = e.data;
    check("q_A", 32'(q_A), 32'(last_qa));
    check("q_B", 32'(q_B), 32'(last_qb));
    if (ega) begin
      if (wr_en_A) shadow[addr_A] = data_A;
      else sb.push_back('{side: 1'b0, data: shadow[addr_A]});
    end
    if (egb) begin
      if (wr_en_B) shadow[addr_B] = data_B;
      else sb.push_back('{side: 1'b1, data: shadow[addr_B]});
    end
    rst_s = rst;
    @(posedge clk);
    #1;
    if (rst_s) begin
      last_qa = '0;
      last_qb = '0;
    end
  endtask

  task automatic idle_inputs();
    req_A = 0; req_B = 0; lock_A = 0; lock_B = 0;
    wr_en_A = 0; wr_en_B = 0; addr_A = '0; addr_B = '0;
    data_A = '0; data_B = '0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[i]    = 16'hA000 + 16'(i);
      shadow[i] = 16'hA000 + 16'(i);
    end
    last_qa = '0;
    last_qb = '0;
    idle_inputs();
    rst = 1;
    @(posedge clk);
    #1;

    // Reset with an active read request: no grants, port idle, no later valid.
    req_A = 1; addr_A = 2'd2;
    tick(0, 0);
    tick(0, 0);
    rst = 0;

    // Single read by A.
    tick(1, 0);
    idle_inputs();
    tick(0, 0);

    // Contention alternates A, B, A, B.
    req_A = 1; addr_A = 2'd0;
    req_B = 1; addr_B = 2'd3;
    tick(1, 0);
    tick(0, 1);
    tick(1, 0);
    tick(0, 1);
    idle_inputs();
    tick(0, 0);

    // B locked write then read while A waits; A granted afterwards.
    req_B = 1; lock_B = 1; wr_en_B = 1; addr_B = 2'd1; data_B = 16'h1234;
    tick(0, 1);
    lock_B = 0; wr_en_B = 0; data_B = '0;
    req_A = 1; addr_A = 2'd0;
    tick(0, 1);
    req_B = 0;
    tick(1, 0);
    idle_inputs();
    tick(0, 0);

    // Lock budget: 16 A grants then one forced B grant, repeated.
    req_A = 1; lock_A = 1; addr_A = 2'd0;
    req_B = 1; addr_B = 2'd3;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 16; k++) tick(1, 0);
      tick(0, 1);
    end
    idle_inputs();
    tick(0, 0);

    // Reset while A holds a lock mid-read; afterwards A wins the first contention.
    req_A = 1; lock_A = 1; addr_A = 2'd2;
    req_B = 1; addr_B = 2'd3;
    tick(1, 0);
    rst = 1;
    tick(0, 0);
    rst = 0;
    lock_A = 0;
    tick(1, 0);
    idle_inputs();
    tick(0, 0);
    tick(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
